hazard_control_unit: RTL and testbench

Central sequencing controller for the five-stage pipelined RISC-V core. It drives operand forwarding selects, load-use stalls, and flushes on taken branch/jump. The flush condition is the encoded PC-source select produced in Execute. It also runs the valid/ready handshake with data memory through a small FSM with timeout detection, and keeps saturating hazard performance counters.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/forwarding_unit.sv | 26 ++
 rtl/hazard_control_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: result/PC-source selects,
// forwarding selects and the data-memory handshake FSM states.
package pipeline_pkg;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    PC4    = 2'b00,
    TARGET = 2'b01,
    JALR   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hcu_state_e;

  // A later stage produces a value for rs when it writes a non-x0 register equal to rs.
  function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for one Execute source register; Memory beats Writeback.
module forwarding_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardE
);

  fwd_e sel;

  always_comb begin
    sel = FWD_RF;
    if (reg_match(RegWriteM, RdM, RsE)) begin
      sel = FWD_M;
    end else if (reg_match(RegWriteW, RdW, RsE)) begin
      sel = FWD_W;
    end
  end

  assign ForwardE = sel;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, control-transfer flush,
// data-memory valid/ready wait FSM with timeout, and saturating perf counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       PCSrcE,
  input  logic             MemAccessM,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             dmem_valid,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hcu_state_e       state_q, state_d;
  logic [7:0]       wait_q, wait_d, wait_inc;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall, branch_taken, mem_stall, flush_count;

  forwarding_unit u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (fwd_a)
  );

  forwarding_unit u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (fwd_b)
  );

  assign lw_stall     = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
  assign branch_taken = (PCSrcE != PC4);
  // The miss cycle in RUN already stalls, so the wait looks identical from its first cycle.
  assign mem_stall    = !dmem_ready && ((state_q == MEM_WAIT) || MemAccessM);

  always_comb begin
    dmem_valid  = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    ForwardAE   = FWD_RF;
    ForwardBE   = FWD_RF;
    flush_count = 1'b0;
    if (!rst) begin
      dmem_valid = (state_q == MEM_WAIT) || MemAccessM;
      ForwardAE  = fwd_a;
      ForwardBE  = fwd_b;
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (branch_taken) begin
        FlushD      = 1'b1;
        FlushE      = 1'b1;
        flush_count = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_inc  = (wait_q == '1) ? wait_q : wait_q + 8'd1;
    wait_d    = '0;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (MemAccessM && !dmem_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_d = wait_inc;
        if (wait_inc >= 8'(MAX_WAIT)) timeout_d = 1'b1;
        if (dmem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_count && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (CNT_W=4, MAX_WAIT=4).
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE, PCSrcE;
  logic       MemAccessM, dmem_ready, perf_clr;
  logic       dmem_valid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_timeout;
  logic [3:0] stall_cycles, flush_events;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(4), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .ResultSrcE   (ResultSrcE),
    .PCSrcE       (PCSrcE),
    .MemAccessM   (MemAccessM),
    .dmem_ready   (dmem_ready),
    .perf_clr     (perf_clr),
    .dmem_valid   (dmem_valid),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock edge; inputs change and outputs settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of the control outputs: {dmem_valid,StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [7:0] ctl();
    return {dmem_valid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = '0; PCSrcE = '0;
    MemAccessM = 0; dmem_ready = 0; perf_clr = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Hazard-provoking inputs while in reset: everything must stay quiet.
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1; PCSrcE = 2'b10; MemAccessM = 1;
    tick();
    tick();
    check_eq("rst_ctl", 32'(ctl()), 32'h00);
    check_eq("rst_fwdA", 32'(ForwardAE), 32'h0);
    check_eq("rst_cnt", {24'h0, stall_cycles, flush_events}, 32'h0);
    check_eq("rst_timeout", 32'(mem_timeout), 32'h0);

    clear_inputs();
    rst = 1'b0;
    tick();
    check_eq("idle_ctl", 32'(ctl()), 32'h00);

    // Forwarding
    Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1; RdW = 5'd5; RegWriteW = 1;
    #1 check_eq("fwdA_M", 32'(ForwardAE), 32'h2);
    check_eq("fwdB_M", 32'(ForwardBE), 32'h2);
    RdM = 5'd0;
    #1 check_eq("fwdA_W_rdm0", 32'(ForwardAE), 32'h1);
    Rs2E = 5'd6;
    #1 check_eq("fwdB_none", 32'(ForwardBE), 32'h0);
    RdW = 5'd0;
    #1 check_eq("fwdA_rdw0", 32'(ForwardAE), 32'h0);
    clear_inputs();

    // Load-use stall
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1 check_eq("lw_stall", 32'(ctl()), 32'h62);
    tick();
    check_eq("lw_stall_cnt", 32'(stall_cycles), 32'd1);
    RdE = 5'd0;
    #1 check_eq("lw_rd0", 32'(ctl()), 32'h00);

    // Branch beats load-use
    RdE = 5'd7; PCSrcE = 2'b10;
    #1 check_eq("br_over_lw", 32'(ctl()), 32'h06);
    tick();
    check_eq("br_flush_cnt", 32'(flush_events), 32'd1);
    check_eq("br_stall_cnt", 32'(stall_cycles), 32'd1);
    clear_inputs();

    // Memory wait: ready low three cycles, then high; branch suppressed meanwhile
    MemAccessM = 1; dmem_ready = 0;
    #1 check_eq("mw_run_miss", 32'(ctl()), 32'hF9);
    tick();
    PCSrcE = 2'b01;
    #1 check_eq("mw_wait1", 32'(ctl()), 32'hF9);
    tick();
    check_eq("mw_wait2", 32'(ctl()), 32'hF9);
    tick();
    PCSrcE = 2'b00; dmem_ready = 1;
    #1 check_eq("mw_release", 32'(ctl()), 32'h80);
    tick();
    check_eq("mw_stall_cnt", 32'(stall_cycles), 32'd4);
    check_eq("mw_flush_cnt", 32'(flush_events), 32'd1);
    check_eq("mw_no_timeout", 32'(mem_timeout), 32'd0);
    MemAccessM = 0; dmem_ready = 0;
    #1 check_eq("mw_back_run", 32'(ctl()), 32'h00);

    // Timeout: six cycles with ready low
    MemAccessM = 1;
    for (int i = 0; i < 6; i++) begin
      #1 check_eq("to_stall", 32'(StallM), 32'd1);
      tick();
      check_eq("to_flag", 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    check_eq("to_stall_cnt", 32'(stall_cycles), 32'd10);
    dmem_ready = 1;
    tick();
    check_eq("to_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a wait
    dmem_ready = 0;
    tick();
    rst = 1;
    #1 check_eq("rst_mid_ctl", 32'(ctl()), 32'h00);
    tick();
    check_eq("rst_mid_timeout", 32'(mem_timeout), 32'd0);
    check_eq("rst_mid_cnt", {24'h0, stall_cycles, flush_events}, 32'h0);
    rst = 0; MemAccessM = 0;
    #1 check_eq("rst_mid_run", 32'(ctl()), 32'h00);

    // Saturation and clear priority
    MemAccessM = 1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_15", 32'(stall_cycles), 32'd15);
    perf_clr = 1;
    tick();
    check_eq("clr_prio", 32'(stall_cycles), 32'd0);
    perf_clr = 0;
    tick();
    check_eq("after_clr", 32'(stall_cycles), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
